// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: requester IDs, ID FIFO entries
// and the lock register encoding.
package mem_arb_pkg;

  localparam int MAX_OUTSTANDING_DEF = 2;

  typedef enum logic {
    REQ_IF   = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

  typedef struct packed {
    req_id_t id;
    logic    we;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    LK_FREE = 2'd0,
    LK_IF   = 2'd1,
    LK_DATA = 2'd2
  } lock_state_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order ID FIFO recording which requester owns each in-flight memory
// request; push and pop may occur in the same cycle, including when full.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH = MAX_OUTSTANDING_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fifo_entry_t      push_entry,
  input  logic             pop,
  output fifo_entry_t      head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t      store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters and routes
// in-order responses back. Define MEM_ARB_RR_EN for round-robin arbitration.
//
// lock state | meaning
// LK_FREE    | no stalled request; arbitrate normally
// LK_IF      | fetch was presented but stalled; port reserved for fetch
// LK_DATA    | data was presented but stalled; port reserved for data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W          = 32,
  parameter  int DATA_W          = 32,
  parameter  int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  localparam int BE_W            = DATA_W / 8,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [BE_W-1:0]   d_req_be,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [BE_W-1:0]   mem_req_be,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]  outstanding,
  output logic              proto_err
);

  lock_state_t lock_state;
  lock_state_t lock_next;
  fifo_entry_t head;
  fifo_entry_t push_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        accept;
  logic        both_valid;
  logic        win_valid;
  req_id_t     win_id;
  req_id_t     pref_id;

  assign both_valid = if_req_valid && d_req_valid;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr;  // 1: fetch wins the next collision

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      rr_ptr <= 1'b0;
    else if (accept && both_valid) rr_ptr <= (win_id == REQ_DATA);
  end

  assign pref_id = rr_ptr ? REQ_IF : REQ_DATA;
`else
  assign pref_id = REQ_DATA;
`endif

  always_comb begin
    win_valid = 1'b0;
    win_id    = REQ_DATA;
    lock_next = LK_FREE;
    // No bypass: a response popping this cycle does not free a slot yet.
    if (!rst && !fifo_full) begin
      unique case (lock_state)
        LK_IF: begin
          win_id    = REQ_IF;
          win_valid = if_req_valid;
        end
        LK_DATA: begin
          win_id    = REQ_DATA;
          win_valid = d_req_valid;
        end
        default: begin
          if (both_valid)  win_id = pref_id;
          else             win_id = d_req_valid ? REQ_DATA : REQ_IF;
          win_valid = if_req_valid || d_req_valid;
        end
      endcase
    end
    if (win_valid && !mem_req_ready)
      lock_next = (win_id == REQ_DATA) ? LK_DATA : LK_IF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_state <= LK_FREE;
    else     lock_state <= lock_next;
  end

  assign accept        = win_valid && mem_req_ready;
  assign mem_req_valid = win_valid;
  assign if_req_ready  = accept && (win_id == REQ_IF);
  assign d_req_ready   = accept && (win_id == REQ_DATA);

  always_comb begin
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_be    = '0;
    mem_req_wdata = '0;
    if (win_valid) begin
      if (win_id == REQ_DATA) begin
        mem_req_addr  = d_req_addr;
        mem_req_we    = d_req_we;
        mem_req_be    = d_req_be;
        mem_req_wdata = d_req_wdata;
      end else begin
        mem_req_addr  = if_req_addr;
        mem_req_be    = '1;
      end
    end
  end

  assign push_entry = '{id: win_id, we: (win_id == REQ_DATA) && d_req_we};
  assign pop        = mem_rsp_valid && !rst && !fifo_empty;

  mem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  assign if_rsp_valid = pop && (head.id == REQ_IF);
  assign d_rsp_valid  = pop && (head.id == REQ_DATA);
  assign if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;
  // Store acks carry no data.
  assign d_rsp_data   = (d_rsp_valid && !head.we) ? mem_rsp_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              proto_err <= 1'b0;
    else if (mem_rsp_valid && fifo_empty) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic
// against a queue-based model of the sharing rules.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXO = 2;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_next = 1'b1;
  logic          if_req_valid = 1'b0, if_req_ready;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          d_req_valid = 1'b0, d_req_ready;
  logic [AW-1:0] d_req_addr = '0;
  logic          d_req_we = 1'b0;
  logic [BW-1:0] d_req_be = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          mem_req_valid, mem_req_we;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [BW-1:0] mem_req_be;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic [CW-1:0] outstanding;
  logic          proto_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  typedef struct packed { logic id; logic we; } ent_t;
  typedef struct packed { logic dest; logic [DW-1:0] data; } rsp_t;

  ent_t m_q[$];          // in-flight requests, oldest first (id 1 = data)
  rsp_t exp_rsp_q[$];
  logic m_lock = 1'b0, m_lock_id = 1'b0, m_pref = 1'b1, m_perr = 1'b0;
  logic m_acc = 1'b0, m_acc_id = 1'b0;

  logic          exp_mvalid = 1'b0, exp_if_rdy = 1'b0, exp_d_rdy = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [BW-1:0] exp_be = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            exp_out = 0;
  logic          exp_perr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Apply one cycle of stimulus just after the rising edge and predict the
  // DUT's view of that cycle from the sharing rules.
  task automatic drive(input logic iv, input logic [AW-1:0] ia,
                       input logic dv, input logic [AW-1:0] da, input logic dwe,
                       input logic [BW-1:0] dbe, input logic [DW-1:0] dwd,
                       input logic mrdy, input logic mrv, input logic [DW-1:0] mrd);
    logic win_v, win;
    ent_t e;
    rsp_t r;
    @(posedge clk); #1;
    rst = rst_next;
    if_req_valid = iv;  if_req_addr = ia;
    d_req_valid = dv;   d_req_addr = da;  d_req_we = dwe;  d_req_be = dbe;  d_req_wdata = dwd;
    mem_req_ready = mrdy;  mem_rsp_valid = mrv;  mem_rsp_data = mrd;
    win_v = 1'b0;
    win = 1'b1;
    exp_out = m_q.size();
    exp_perr = m_perr;
    if (rst) begin
      m_q.delete();
      m_lock = 1'b0;  m_pref = 1'b1;  m_perr = 1'b0;
      exp_out = 0;  exp_perr = 1'b0;
    end else begin
      if (m_q.size() < MAXO) begin
        if (m_lock)          begin win = m_lock_id; win_v = m_lock_id ? dv : iv; end
        else if (iv && dv)   begin win = m_pref;    win_v = 1'b1; end
        else                 begin win = dv;        win_v = iv || dv; end
      end
      if (mrv) begin
        if (m_q.size() == 0) m_perr = 1'b1;
        else begin
          e = m_q.pop_front();
          r.dest = e.id;
          r.data = e.we ? DW'(0) : mrd;
          exp_rsp_q.push_back(r);
        end
      end
      if (win_v && mrdy) begin
        e.id = win;
        e.we = win && dwe;
        m_q.push_back(e);
`ifdef MEM_ARB_RR_EN
        if (iv && dv) m_pref = ~win;
`endif
      end
      m_lock = win_v && !mrdy;
      m_lock_id = win;
    end
    exp_mvalid = win_v;
    exp_if_rdy = win_v && !win && mrdy;
    exp_d_rdy  = win_v && win && mrdy;
    exp_addr   = win ? da : ia;
    exp_we     = win && dwe;
    exp_be     = win ? dbe : '1;
    exp_wdata  = win ? dwd : '0;
    m_acc      = win_v && mrdy;
    m_acc_id   = win;
  endtask

  task automatic idle_cycle(input logic mrv, input logic [DW-1:0] mrd);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b1, mrv, mrd);
  endtask

  task automatic drain();
    while (m_q.size() > 0) idle_cycle(1'b1, $urandom);
    idle_cycle(1'b0, '0);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares the request side every cycle and pops the scoreboard
  // whenever a response appears.
  always @(negedge clk) begin
    rsp_t e;
    logic any;
    chk("mem_req_valid", DW'(mem_req_valid), DW'(exp_mvalid));
    chk("if_req_ready", DW'(if_req_ready), DW'(exp_if_rdy));
    chk("d_req_ready", DW'(d_req_ready), DW'(exp_d_rdy));
    if (exp_mvalid) begin
      chk("mem_req_addr", mem_req_addr, exp_addr);
      chk("mem_req_we", DW'(mem_req_we), DW'(exp_we));
      chk("mem_req_be", DW'(mem_req_be), DW'(exp_be));
      chk("mem_req_wdata", mem_req_wdata, exp_wdata);
    end
    chk("outstanding", DW'(outstanding), DW'(exp_out));
    chk("proto_err", DW'(proto_err), DW'(exp_perr));
    any = if_rsp_valid || d_rsp_valid;
    chk("rsp_present", DW'(any), DW'(exp_rsp_q.size() != 0));
    if (any) chk("rsp_single", DW'(if_rsp_valid && d_rsp_valid), 0);
    if (any && exp_rsp_q.size() != 0) begin
      e = exp_rsp_q.pop_front();
      chk("rsp_dest", DW'(d_rsp_valid), DW'(e.dest));
      chk("rsp_data", d_rsp_valid ? d_rsp_data : if_rsp_data, e.data);
    end
    while (exp_rsp_q.size() != 0) void'(exp_rsp_q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic          r_iv, r_dv, r_dwe, mrdy, mrv;
  logic [AW-1:0] r_ia, r_da;
  logic [BW-1:0] r_dbe;
  logic [DW-1:0] r_dwd;

  initial begin
    rst_next = 1'b1;
    repeat (2) idle_cycle(1'b0, '0);
    rst_next = 1'b0;
    idle_cycle(1'b0, '0);

    // fetch only
    drive(1'b1, 32'h10, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    idle_cycle(1'b1, 32'h0010_0093);
    idle_cycle(1'b0, '0);

    // contention, two back-to-back collisions
    drive(1'b1, 32'h20, 1'b1, 32'h100, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    drive(1'b1, 32'h20, 1'b1, 32'h104, 1'b0, 4'hF, '0, 1'b1, 1'b1, 32'h1111_0000);
    drain();

    // stall lock: fetch held off 3 cycles, data joins in cycle 2
    drive(1'b1, 32'h40, 1'b0, '0, 1'b0, 4'hF, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 4'hF, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 4'hF, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'h300, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    drain();

    // full FIFO: third request waits, including through the response cycle
    drive(1'b0, '0, 1'b1, 32'h400, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 32'h404, 1'b0, 4'hF, '0, 1'b1, 1'b0, '0);
    drive(1'b1, 32'h50, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    drive(1'b1, 32'h50, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hA5A5_0001);
    drive(1'b1, 32'h50, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    drain();

    // store ack
    drive(1'b0, '0, 1'b1, 32'h200, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
    idle_cycle(1'b1, 32'h1234_5678);
    idle_cycle(1'b0, '0);

    // stray response, sticky error, reset during a stall
    idle_cycle(1'b1, 32'hCAFE_0000);
    idle_cycle(1'b0, '0);
    idle_cycle(1'b0, '0);
    drive(1'b1, 32'h60, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h60, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    rst_next = 1'b1;
    drive(1'b1, 32'h60, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    rst_next = 1'b0;
    idle_cycle(1'b0, '0);
    idle_cycle(1'b0, '0);

    // random traffic; requesters hold each request until it is accepted
    r_iv = 1'b0; r_ia = '0; r_dv = 1'b0; r_da = '0; r_dwe = 1'b0; r_dbe = '0; r_dwd = '0;
    for (int c = 0; c < 3000; c++) begin
      rst_next = (c % 500 == 499);
      mrdy = ($urandom_range(0, 3) != 0);
      mrv  = ((m_q.size() != 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 299) == 0);
      drive(r_iv, r_ia, r_dv, r_da, r_dwe, r_dbe, r_dwd, mrdy, mrv, $urandom);
      if (!r_iv || (m_acc && !m_acc_id)) begin
        r_iv = 1'($urandom_range(0, 1));
        r_ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!r_dv || (m_acc && m_acc_id)) begin
        r_dv  = 1'($urandom_range(0, 1));
        r_da  = $urandom & 32'hFFFF_FFFC;
        r_dwe = 1'($urandom_range(0, 1));
        r_dbe = BW'($urandom);
        r_dwd = $urandom;
      end
    end
    rst_next = 1'b0;
    drain();

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the load/store requester of the RV32I core.
- Lets fetch and data memory sit behind a single unified memory, which the multi-cycle/pipelined core build needs.
- Both sides use valid/ready request channels and in-order response channels.
- A small ID FIFO tracks outstanding requests so each response is routed back to the requester that issued it.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_OUTSTANDING, 2, maximum in-flight memory requests; legal range 1..8.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch response valid, one cycle
- if_rsp_data  out  DATA_W  fetched instruction
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_req_addr  in  ADDR_W  data address
- d_req_we  in  1  1 = store, 0 = load
- d_req_be  in  DATA_W/8  store byte enables
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  data response valid; for stores it is an ack
- d_rsp_data  out  DATA_W  load data; 0 for store acks
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  request address
- mem_req_we  out  1  write enable
- mem_req_be  out  DATA_W/8  byte enables; all ones for fetch
- mem_req_wdata  out  DATA_W  write data; 0 for fetch
- mem_rsp_valid  in  1  in-order response valid, one per accepted request
- mem_rsp_data  in  DATA_W  response data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight count
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync release):
  - Clears the ID FIFO, outstanding, the lock register, proto_err and the RR pointer.
  - While rst is high, all *_valid and *_ready outputs are 0.
- Arbitration:
  - Default is fixed priority, data over fetch.
  - A winner is chosen only when outstanding < MAX_OUTSTANDING and no lock is held.
  - mem_req_* mirror the winner's fields combinationally (zero latency).
- Lock:
  - If mem_req_valid=1 and mem_req_ready=0, the winner's ID is latched into the lock register.
  - While locked, the same requester keeps the port regardless of priority, and the requester must hold its fields stable.
  - The lock clears on the handshake.
- Handshake: a request is accepted when mem_req_valid && mem_req_ready.
  - The winner's *_req_ready equals mem_req_ready; the loser's ready is 0.
  - On acceptance, the winner ID (0 = fetch, 1 = data) is pushed into the FIFO.
- Full FIFO: when outstanding == MAX_OUTSTANDING, mem_req_valid=0 and both readies are 0. This holds even if a response pops in the same cycle (no bypass).
- Responses:
  - When mem_rsp_valid=1, the FIFO head selects the destination and the head is popped.
  - The destination *_rsp_valid pulses for one cycle with mem_rsp_data; the other rsp_valid stays 0.
  - Store ack: d_rsp_data = 0. A per-entry we bit is stored in the FIFO for this.
- Simultaneous push and pop: outstanding is unchanged, and both the FIFO and the routing are correct.
- Response with empty FIFO: the response is dropped, no rsp_valid is raised, and proto_err sets and stays set until reset.
- Reset mid-transaction: all in-flight IDs are discarded. Later stray responses set proto_err, so memory must be reset together with this block.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer flips to the non-winning requester after each accepted request, provided both were valid that cycle.
- Undefined: fixed data-over-fetch priority, with no pointer register.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic {REQ_IF=0, REQ_DATA=1} req_id_t
  - a struct {req_id_t id; logic we;} fifo_entry_t
  - the MAX_OUTSTANDING default
- Sub-module mem_arb_id_fifo: synchronous FIFO of fifo_entry_t with depth MAX_OUTSTANDING, push/pop/full/empty/count, and simultaneous push+pop supported.

Test Plan:
- Fetch-only: if_req_valid=1 addr 0x0000_0010, mem ready=1, memory answers 0x0010_0093 next cycle -> if_rsp_valid pulses once with 0x0010_0093, outstanding goes 0→1→0.
- Contention: both valid in the same cycle, fetch 0x20 and load 0x100 -> data is granted first. Under MEM_ARB_RR_EN, the second back-to-back collision grants fetch.
- Stall lock: fetch presented while mem_req_ready=0 for 3 cycles, then d_req_valid rises in cycle 2 -> the port stays with fetch until the handshake, then data wins.
- Full FIFO with MAX_OUTSTANDING=2: two accepted loads, no responses -> mem_req_valid=0 while a third request waits. After one response, the third request is accepted the following cycle.
- Store ack: store addr 0x200, be=4'b0011, wdata 0xDEAD_BEEF -> mem_req_we=1, be=0011. The response produces d_rsp_valid=1 with d_rsp_data=0.
- Error and reset: mem_rsp_valid with an empty FIFO -> no rsp_valid, proto_err=1 and sticky. Asserting rst mid-stall clears proto_err, outstanding and all valids immediately.
